rename_checkpoint_ctrl: RTL



---
 rtl/drac_pkg.sv | 25 ++
 rtl/rename_checkpoint_ctrl.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/drac_pkg.sv
// +----------------------------------------------------------------------+
// | Module : drac_pkg                                                    |
// | Brief  : Shared checkpoint types and defaults for the rename stage.  |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package drac_pkg;

   // Number of checkpoint versions shared by the free list and rename table
   localparam int NUM_CHECKPOINTS = 4;
   localparam int CKPT_W          = $clog2(NUM_CHECKPOINTS);

   typedef logic [CKPT_W-1:0] checkpoint_ptr;

   // Checkpoint controller sequencing states
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RECOVER = 2'd1,
      STALL   = 2'd2
   } ckpt_ctrl_state_t;

endpackage

`default_nettype wire

// File: rtl/rename_checkpoint_ctrl.sv
// +----------------------------------------------------------------------+
// | Module : rename_checkpoint_ctrl                                      |
// | Brief  : Grants branch checkpoints, retires them oldest-first and    |
// |          sequences recovery on mispredict or commit rollback.        |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module rename_checkpoint_ctrl #(
   parameter int NUM_CHECKPOINTS = drac_pkg::NUM_CHECKPOINTS,
   parameter int CKPT_W          = $clog2(NUM_CHECKPOINTS),
   parameter int RECOVER_STALL   = 2
) (
   input  logic              clk_i,
   input  logic              rstn_i,
   input  logic              br_req_i,
   output logic              br_stall_o,
   output logic              do_checkpoint_o,
   output logic [CKPT_W-1:0] checkpoint_label_o,
   input  logic              resolve_valid_i,
   input  logic [CKPT_W-1:0] resolve_label_i,
   input  logic              resolve_mispredict_i,
   output logic              do_recover_o,
   output logic [CKPT_W-1:0] recover_label_o,
   output logic              delete_checkpoint_o,
   input  logic              commit_roll_back_i,
   output logic              out_of_checkpoints_o,
   output logic              recovering_o
);

   localparam int CNT_W = CKPT_W + 1;
   localparam int SC_W  = (RECOVER_STALL > 1) ? $clog2(RECOVER_STALL) : 1;

   // Distance of a label from the oldest live checkpoint, modulo the ring size
   function automatic logic [CKPT_W-1:0] ckpt_age(input logic [CKPT_W-1:0] lbl,
                                                  input logic [CKPT_W-1:0] base);
      return lbl - base;
   endfunction

   logic [CKPT_W-1:0]          head_q;
   logic [CKPT_W-1:0]          tail_q;
   logic [CNT_W-1:0]           count_q;
   logic [NUM_CHECKPOINTS-1:0] resolved_q;
   drac_pkg::ckpt_ctrl_state_t state_q, state_d;
   logic [SC_W-1:0]            stall_q, stall_d;

   logic [CKPT_W-1:0] label_age;
   logic [CKPT_W-1:0] head_inc;
   logic              label_live;
   logic              mp;
   logic              good_resolve;
   logic              grant;
   logic              del;

   assign label_age    = ckpt_age(resolve_label_i, tail_q);
   assign label_live   = {1'b0, label_age} < count_q;
   assign head_inc     = head_q + CKPT_W'(1);

   // A mispredict only counts for a label that is still in flight; rollback overrides it
   assign mp           = resolve_valid_i & resolve_mispredict_i & label_live & ~commit_roll_back_i;
   assign good_resolve = resolve_valid_i & ~resolve_mispredict_i & label_live;

   // One slot is always kept spare so head never catches up with tail
   assign grant = br_req_i & (state_q == drac_pkg::IDLE)
                & (count_q < CNT_W'(NUM_CHECKPOINTS - 1)) & ~mp & ~commit_roll_back_i;
   assign del   = (count_q != '0) & resolved_q[tail_q] & ~mp & ~commit_roll_back_i;

   assign do_checkpoint_o      = grant;
   assign checkpoint_label_o   = head_q;
   assign br_stall_o           = br_req_i & ~grant;
   assign do_recover_o         = mp;
   assign recover_label_o      = resolve_label_i;
   assign delete_checkpoint_o  = del;
   assign out_of_checkpoints_o = (count_q == CNT_W'(NUM_CHECKPOINTS - 1));
   assign recovering_o         = (state_q != drac_pkg::IDLE);

   // Checkpoint ring pointers, occupancy and per-label resolution flags
   always_ff @(posedge clk_i) begin
      if (!rstn_i || commit_roll_back_i) begin
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         resolved_q <= '0;
      end else if (mp) begin
         head_q  <= resolve_label_i;
         count_q <= {1'b0, label_age};
         // The mispredicted label and everything younger is discarded
         for (int i = 0; i < NUM_CHECKPOINTS; i++) begin
            if (ckpt_age(CKPT_W'(i), tail_q) >= label_age) begin
               resolved_q[i] <= 1'b0;
            end
         end
      end else begin
         if (good_resolve) begin
            resolved_q[resolve_label_i] <= 1'b1;
         end
         if (del) begin
            resolved_q[tail_q] <= 1'b0;
            tail_q             <= tail_q + CKPT_W'(1);
         end
         if (grant) begin
            resolved_q[head_inc] <= 1'b0;
            head_q               <= head_inc;
         end
         case ({grant, del})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Recovery FSM state and stall counter registers
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state_q <= drac_pkg::IDLE;
         stall_q <= '0;
      end else begin
         state_q <= state_d;
         stall_q <= stall_d;
      end
   end

   // Recovery FSM next-state: rollback aborts, mispredict (re)enters RECOVER
   always_comb begin
      state_d = state_q;
      stall_d = stall_q;
      if (commit_roll_back_i) begin
         state_d = drac_pkg::IDLE;
         stall_d = '0;
      end else if (mp) begin
         state_d = drac_pkg::RECOVER;
         stall_d = SC_W'(RECOVER_STALL - 1);
      end else begin
         case (state_q)
            drac_pkg::RECOVER: begin
               state_d = (RECOVER_STALL == 1) ? drac_pkg::IDLE : drac_pkg::STALL;
            end
            drac_pkg::STALL: begin
               if (stall_q <= SC_W'(1)) begin
                  state_d = drac_pkg::IDLE;
               end else begin
                  stall_d = stall_q - SC_W'(1);
               end
            end
            default: state_d = drac_pkg::IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire
